// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory controller with programmable wait states,
// little-endian byte/halfword/word access and alignment/range fault detection.
module data_mem_ctrl #(
    parameter int DEPTH       = 2048,
    parameter int BASE        = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        w_en,
    input  logic        r_en,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [7:0]  mem [DEPTH];

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_sx;
    logic        lat_wr;
    logic        lat_both;

    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sx;
    logic        req_wr;
    logic        req_both;

    logic [2:0]  req_bytes;
    logic [31:0] offset;
    logic [32:0] end_pos;
    logic        out_range;
    logic        misalign;
    logic        fault;
    logic [AW-1:0] idx;
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] load_val;
    logic        mem_we;

    // In IDLE the live inputs are evaluated so a zero-wait access can finish on the accept edge.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        req_addr  = lat_addr;
        req_wdata = lat_wdata;
        req_size  = lat_size;
        req_sx    = lat_sx;
        req_wr    = lat_wr;
        req_both  = lat_both;
        if (state == IDLE) begin
            req_addr  = addr;
            req_wdata = wdata;
            req_size  = size;
            req_sx    = sign_ext;
            req_wr    = w_en;
            req_both  = w_en & r_en;
        end
    end

    always_comb begin
        case (req_size)
            2'b00:   req_bytes = 3'd1;
            2'b01:   req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
    end

    // The 33-bit sum keeps offsets just below 2^32 from wrapping back into range.
    assign offset    = req_addr - 32'(BASE);
    assign end_pos   = {1'b0, offset} + {30'b0, req_bytes};
    assign out_range = end_pos > 33'(DEPTH);
    assign misalign  = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign fault     = out_range || misalign || (req_size == 2'b11) || req_both;
    assign idx       = offset[AW-1:0];

    assign b0 = mem[idx];
    assign b1 = mem[idx + AW'(1)];
    assign b2 = mem[idx + AW'(2)];
    assign b3 = mem[idx + AW'(3)];

    always_comb begin
        case (req_size)
            2'b00:   load_val = {{24{req_sx & b0[7]}}, b0};
            2'b01:   load_val = {{16{req_sx & b1[7]}}, b1, b0};
            default: load_val = {b3, b2, b1, b0};
        endcase
    end

    assign mem_we = (state == DONE) && lat_wr && !fault;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
            state     <= IDLE;
            cnt       <= 4'd0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_size  <= 2'b00;
            lat_sx    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_both  <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (w_en || r_en) begin
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_size  <= size;
                        lat_sx    <= sign_ext;
                        lat_wr    <= w_en;
                        lat_both  <= w_en & r_en;
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                            ready <= 1'b1;
                            err   <= fault;
                            rdata <= (!req_wr && !fault) ? load_val : 32'd0;
                        end else begin
                            state <= BUSY;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                        ready <= 1'b1;
                        err   <= fault;
                        rdata <= (!req_wr && !fault) ? load_val : 32'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stores commit on the edge leaving DONE; an async reset in BUSY/DONE therefore drops them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this array is reset on purpose: every byte must power up holding its own index.
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < req_bytes) mem[idx + AW'(k)] <= req_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl: a WAIT_CYCLES=3 instance for
// function/fault/reset behaviour and a WAIT_CYCLES=0 instance for back-to-back timing.
module tb_data_mem_ctrl;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;

    logic [31:0] addr, wdata;
    logic        w_en, r_en, sign_ext;
    logic [1:0]  size;
    logic [31:0] rdata;
    logic        ready, err;

    logic [31:0] addr1, wdata1;
    logic        w_en1, r_en1, sign_ext1;
    logic [1:0]  size1;
    logic [31:0] rdata1;
    logic        ready1, err1;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad   = 0;

    data_mem_ctrl #(.DEPTH(2048), .BASE(1024), .WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .w_en(w_en), .r_en(r_en),
        .size(size), .sign_ext(sign_ext), .rdata(rdata), .ready(ready), .err(err)
    );

    data_mem_ctrl #(.DEPTH(2048), .BASE(1024), .WAIT_CYCLES(0)) dut0w (
        .clk(clk), .rst(rst), .addr(addr1), .wdata(wdata1), .w_en(w_en1), .r_en(r_en1),
        .size(size1), .sign_ext(sign_ext1), .rdata(rdata1), .ready(ready1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop one expectation from the WAIT_CYCLES=3 scoreboard and compare it with the outputs.
    task automatic score0(input string tag);
        exp_t e;
        if (q0.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(q0.size()), 32'd1);
        end else begin
            e = q0.pop_front();
            check({tag, "_rdata"}, rdata, e.rdata);
            check({tag, "_err"}, {31'b0, err}, {31'b0, e.err});
        end
    endtask

    // Called at a negedge; presents the request immediately (cycle 1) and waits for ready.
    task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic re, input logic [1:0] sz,
                          input logic sx, input logic [31:0] exp_rd, input logic exp_err);
        int  cyc;
        bit  got;
        q0.push_back('{rdata: exp_rd, err: exp_err});
        addr = a; wdata = wd; w_en = we; r_en = re; size = sz; sign_ext = sx;
        cyc = 1;
        got = 1'b0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            if (ready) got = 1'b1;
        end
        check({tag, "_timeout"}, {31'b0, got}, 32'd1);
        if (got) begin
            check({tag, "_lat"}, 32'(cyc), 32'd5);
            score0(tag);
        end
        w_en = 1'b0; r_en = 1'b0;
        @(negedge clk);
        check({tag, "_after"}, {rdata[31:1], rdata[0] | ready | err}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        addr = 0; wdata = 0; w_en = 0; r_en = 0; size = 0; sign_ext = 0;
        addr1 = 0; wdata1 = 0; w_en1 = 0; r_en1 = 0; size1 = 0; sign_ext1 = 0;
        #1;
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // First edge after reset release accepts the request.
        access("ld_w_1024", 32'd1024, 0, 0, 1, 2'b10, 0, 32'h03020100, 0);
        access("ld_b_1152_s", 32'd1152, 0, 0, 1, 2'b00, 1, 32'hFFFFFF80, 0);
        access("ld_b_1152_u", 32'd1152, 0, 0, 1, 2'b00, 0, 32'h00000080, 0);
        access("st_w_1028", 32'd1028, 32'hDEADBEEF, 1, 0, 2'b10, 0, 32'd0, 0);
        access("ld_h_1030_u", 32'd1030, 0, 0, 1, 2'b01, 0, 32'h0000DEAD, 0);
        access("ld_b_1028", 32'd1028, 0, 0, 1, 2'b00, 1, 32'hFFFFFFEF, 0);
        access("ld_b_1028_u", 32'd1028, 0, 0, 1, 2'b00, 0, 32'h000000EF, 0);
        access("ld_h_1030_s", 32'd1030, 0, 0, 1, 2'b01, 1, 32'hFFFFDEAD, 0);
        access("ld_w_1028_s", 32'd1028, 0, 0, 1, 2'b10, 1, 32'hDEADBEEF, 0);

        // Faults.
        access("ld_w_mis", 32'd1026, 0, 0, 1, 2'b10, 0, 32'd0, 1);
        access("st_w_oor", 32'd3072, 32'hCAFEF00D, 1, 0, 2'b10, 0, 32'd0, 1);
        access("ld_w_1024b", 32'd1024, 0, 0, 1, 2'b10, 0, 32'h03020100, 0);
        access("ld_h_mis", 32'd3071, 0, 0, 1, 2'b01, 0, 32'd0, 1);
        access("ld_below", 32'd1020, 0, 0, 1, 2'b10, 0, 32'd0, 1);
        access("ld_sz11", 32'd1024, 0, 0, 1, 2'b11, 0, 32'd0, 1);
        access("both_en", 32'd1040, 32'hAAAAAAAA, 1, 1, 2'b10, 0, 32'd0, 1);
        access("ld_w_1040", 32'd1040, 0, 0, 1, 2'b10, 0, 32'h13121110, 0);

        // Top-of-memory boundary.
        access("ld_w_top", 32'd3068, 0, 0, 1, 2'b10, 0, 32'hFFFEFDFC, 0);
        access("ld_h_top", 32'd3070, 0, 0, 1, 2'b01, 0, 32'h0000FFFE, 0);
        access("ld_b_top", 32'd3071, 0, 0, 1, 2'b00, 0, 32'h000000FF, 0);
        access("ld_w_over", 32'd3069, 0, 0, 1, 2'b10, 0, 32'd0, 1);

        // Byte and halfword stores only touch their own lanes.
        access("st_b_1044", 32'd1044, 32'h1234565A, 1, 0, 2'b00, 0, 32'd0, 0);
        access("st_h_1050", 32'd1050, 32'h9999A5C3, 1, 0, 2'b01, 0, 32'd0, 0);
        access("ld_w_1044", 32'd1044, 0, 0, 1, 2'b10, 0, 32'h1716155A, 0);
        access("ld_w_1048", 32'd1048, 0, 0, 1, 2'b10, 0, 32'hA5C31918, 0);

        // Reset during BUSY aborts the store.
        addr = 32'd1032; wdata = 32'h11223344; w_en = 1; r_en = 0; size = 2'b10;
        @(negedge clk);
        w_en = 0;
        #2 rst = 1'b0;
        #1;
        check("rst_busy_ready", {31'b0, ready}, 32'd0);
        check("rst_busy_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        access("ld_w_1032", 32'd1032, 0, 0, 1, 2'b10, 0, 32'h0B0A0908, 0);
        check("rst_restored", {31'b0, q0.size() == 0}, 32'd1);

        // Zero-wait instance: back-to-back loads held continuously.
        q1.push_back('{rdata: 32'h03020100, err: 1'b0});
        q1.push_back('{rdata: 32'h07060504, err: 1'b0});
        addr1 = 32'd1024; r_en1 = 1; size1 = 2'b10;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            if (c == 2 || c == 4) begin
                check($sformatf("w0_ready_c%0d", c), {31'b0, ready1}, 32'd1);
                if (q1.size() != 0) begin
                    exp_t e;
                    e = q1.pop_front();
                    check($sformatf("w0_rdata_c%0d", c), rdata1, e.rdata);
                    check($sformatf("w0_err_c%0d", c), {31'b0, err1}, {31'b0, e.err});
                end else begin
                    check("w0_sb_empty", 32'(q1.size()), 32'd1);
                end
                addr1 = 32'd1028;
                if (c == 4) r_en1 = 0;
            end else begin
                check($sformatf("w0_ready_c%0d", c), {31'b0, ready1}, 32'd0);
                check($sformatf("w0_rdata_c%0d", c), rdata1, 32'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2048: memory size in bytes, a power of two from 256 to 65536.
REQ-002 SHALL have parameter BASE, default 1024: byte address mapped to memory byte 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 3, range 0..15: extra access cycles.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port addr, input, 32: byte address of the request.
REQ-007 SHALL have port wdata, input, 32: store data, right-aligned.
REQ-008 SHALL have port w_en, input, 1: store request.
REQ-009 SHALL have port r_en, input, 1: load request.
REQ-010 SHALL have port size, input, 2: access size; 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-011 SHALL have port sign_ext, input, 1: sign-extends byte and halfword loads when 1.
REQ-012 SHALL have port rdata, output, 32: load result.
REQ-013 SHALL have port ready, output, 1: access complete; the pipeline stalls while a request is high and ready is low.
REQ-014 SHALL have port err, output, 1: the completed access faulted.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-016 In IDLE, a rising edge with w_en or r_en high SHALL latch addr, wdata, size, sign_ext and the operation type.
  - SHALL move to BUSY when WAIT_CYCLES > 0.
  - SHALL move directly to DONE when WAIT_CYCLES = 0.
REQ-017 BUSY SHALL use a 4-bit down-counter loaded with WAIT_CYCLES-1 and move to DONE on the edge where the counter equals 0.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 ready SHALL be 1 only in DONE.
  - ready therefore first asserts WAIT_CYCLES+1 cycles after the request is first presented in IDLE.
REQ-020 rdata and err SHALL be valid only in DONE and SHALL read as 0 in every other state.
REQ-021 Once latched, a request SHALL complete even if w_en, r_en or addr change or drop during BUSY.
REQ-022 The memory offset SHALL be computed as addr-BASE in 32-bit unsigned arithmetic.
  - The access is out of range when offset+bytes > DEPTH.
  - bytes = 1, 2 or 4 according to size.
REQ-023 The access SHALL fault (err=1) under any of these conditions:
  - out of range;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00;
  - size=11;
  - w_en and r_en both high at acceptance.
REQ-024 When w_en and r_en are both high, the access SHALL be treated as a store for fault purposes.
  - Because it faults, nothing is written.
REQ-025 Stores SHALL be little-endian: wdata[7:0] goes to byte offset, wdata[15:8] to offset+1, and so on for the size.
  - Stores SHALL commit on the edge leaving DONE.
  - Faulting stores SHALL write nothing.
REQ-026 Loads SHALL assemble bytes little-endian in DONE.
  - The result is zero-extended, or sign-extended from bit 7 (byte) or bit 15 (halfword) when sign_ext=1.
  - Word loads ignore sign_ext.
REQ-027 A faulting load SHALL return rdata=0.
REQ-028 A new request present in the cycle after DONE SHALL be accepted normally, giving back-to-back throughput of one access per WAIT_CYCLES+2 cycles.

Reset
REQ-029 rst=0 SHALL immediately force state to IDLE, counter to 0, and ready, err and rdata to 0, regardless of the clock.
REQ-030 rst=0 SHALL initialise every memory byte i to i[7:0].
REQ-031 A store in BUSY or DONE when reset asserts SHALL NOT commit.
REQ-032 After rst deasserts, the first rising edge SHALL be able to accept a request.

Verification (WAIT_CYCLES=3, BASE=1024, DEPTH=2048 unless stated)
REQ-033 Post-reset word load, addr=1024 -> ready high in the 5th cycle, rdata=0x03020100, err=0.
REQ-034 Byte load at addr=1152 -> sign_ext=1 gives rdata=0xFFFFFF80; sign_ext=0 gives 0x00000080.
REQ-035 Word store of 0xDEADBEEF at 1028, then halfword load at 1030 unsigned -> rdata=0x0000DEAD; byte load at 1028 -> 0x000000EF.
REQ-036 Word load at 1026, and word store at 3072 -> err=1, rdata=0 and memory unchanged in both cases; a subsequent word load at 1024 still returns 0x03020100.
REQ-037 Word store of 0x11223344 at 1032 with rst pulsed low during BUSY -> state IDLE at once, and a word load at 1032 returns 0x0B0A0908.
REQ-038 WAIT_CYCLES=0, back-to-back loads at 1024 and 1028 -> ready pulses on cycles 2 and 4, with rdata 0x03020100 then 0x07060504.
